mem_access_unit: RTL and testbench

//  MEM-stage consumer of the decoded control word: turns data_mem_read/data_mem_write, funct3 and ALU address into a

---
 rtl/mem_access_unit_pkg.sv | 40 ++++
 rtl/mem_align.sv | 31 +++
 rtl/mem_access_unit.sv | 123 ++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage access unit: funct3 encodings, FSM state and
// the registered dcache request bundle.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  // Access size is funct3[1:0] for both loads and stores.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } acc_size_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
  } dreq_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane alignment: access size + low address bits give the
// byte enables, the lane-shifted store data and the misalignment flag.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  output logic [3:0]  mbe_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    mbe_o      = 4'b1111;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: mbe_o = 4'b0001 << addr_lo_i;
      SZ_H: begin
        mbe_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        misalign_o = addr_lo_i[0];
      end
      SZ_W: misalign_o = (addr_lo_i != 2'b00);
      default: ;
    endcase
  end

  // Stores always shift by the byte offset; the enables select the live lanes.
  assign wdata_o = store_data_i << {addr_lo_i, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access: issues one outstanding dcache request per
// instruction, stalls until the response, and captures the raw load word.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        pipe_advance_i,
  output logic        data_read_o,
  output logic        data_write_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_mbe_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_resp_i,
  input  logic [31:0] data_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  mau_state_t        state_q, state_d;
  dreq_t             req_q, req_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       load_q, load_d;

  logic [3:0]  mbe;
  logic [31:0] wdata;
  logic        mis;
  logic        any_op;
  logic        mem_op;

  mem_align u_align (
    .size_i       (funct3_i[1:0]),
    .addr_lo_i    (addr_i[1:0]),
    .store_data_i (store_data_i),
    .mbe_o        (mbe),
    .wdata_o      (wdata),
    .misalign_o   (mis)
  );

  assign any_op = valid_i & (mem_read_i | mem_write_i);
  assign mem_op = any_op & ~mis;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    load_d     = load_q;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (state_q)
      IDLE: begin
        misalign_o = any_op & mis;
        if (mem_op) begin
          // Read+write together is resolved as a write.
          req_d.rd    = mem_read_i & ~mem_write_i;
          req_d.wr    = mem_write_i;
          req_d.addr  = {addr_i[31:2], 2'b00};
          req_d.mbe   = mbe;
          req_d.wdata = wdata;
          cnt_d       = '0;
          stall_o     = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        stall_o = ~data_resp_i;
        if (data_resp_i) begin
          req_d.rd = 1'b0;
          req_d.wr = 1'b0;
          if (req_q.rd) load_d = data_rdata_i;
          cnt_d   = '0;
          state_d = pipe_advance_i ? IDLE : DONE;
        end else begin
          if (cnt_q != WAIT_W'(MAX_WAIT)) cnt_d = cnt_q + 1'b1;
          if (cnt_d == WAIT_W'(MAX_WAIT)) timeout_d = 1'b1;
        end
      end
      DONE: begin
        // Same instruction still sits in MEM; wait for it to leave.
        if (pipe_advance_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      load_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      load_q    <= load_d;
    end
  end

  assign data_read_o  = req_q.rd;
  assign data_write_o = req_q.wr;
  assign data_addr_o  = req_q.addr;
  assign data_mbe_o   = req_q.mbe;
  assign data_wdata_o = req_q.wdata;
  assign load_data_o  = load_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single accesses plus
// hand-written stall, DONE, reset-in-REQ and watchdog sequences.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic        pipe_advance_i;
  logic        data_read_o, data_write_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_mbe_o;
  logic [31:0] data_wdata_o;
  logic        data_resp_i;
  logic [31:0] data_rdata_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        misalign_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .funct3_i       (funct3_i),
    .addr_i         (addr_i),
    .store_data_i   (store_data_i),
    .pipe_advance_i (pipe_advance_i),
    .data_read_o    (data_read_o),
    .data_write_o   (data_write_o),
    .data_addr_o    (data_addr_o),
    .data_mbe_o     (data_mbe_o),
    .data_wdata_o   (data_wdata_o),
    .data_resp_i    (data_resp_i),
    .data_rdata_i   (data_rdata_i),
    .stall_o        (stall_o),
    .load_data_o    (load_data_o),
    .misalign_o     (misalign_o),
    .timeout_o      (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic        mis;
  } vec_t;

  vec_t vt[13];
  logic [31:0] last_load;

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] sd, logic [31:0] rdata, logic [3:0] mbe,
                              logic [31:0] wdata, logic mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata;
    v.mbe = mbe; v.wdata = wdata; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_i = 0; mem_read_i = 0; mem_write_i = 0; funct3_i = 0;
    addr_i = 0; store_data_i = 0; pipe_advance_i = 0;
    data_resp_i = 0; data_rdata_i = 0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd);
    valid_i = 1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    addr_i = addr; store_data_i = sd; pipe_advance_i = 0;
  endtask

  initial begin
    int stalls;
    int reqs;
    rst = 1;
    drive_idle();
    last_load = 32'h0;

    vt[0]  = mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 0);
    vt[1]  = mk(0, 1, 3'b000, 32'h103, 32'h000000AB, 32'h0,        4'b1000, 32'hAB000000, 0);
    vt[2]  = mk(0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0,        4'b1100, 32'h12340000, 0);
    vt[3]  = mk(0, 1, 3'b000, 32'h101, 32'h00000055, 32'h0,        4'b0010, 32'h00005500, 0);
    vt[4]  = mk(1, 0, 3'b001, 32'h202, 32'h0,        32'h8001BEEF, 4'b1100, 32'h0,        0);
    vt[5]  = mk(1, 0, 3'b000, 32'h207, 32'h0,        32'h11223344, 4'b1000, 32'h0,        0);
    vt[6]  = mk(1, 0, 3'b010, 32'h300, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h0,        0);
    vt[7]  = mk(1, 0, 3'b010, 32'h201, 32'h0,        32'h0,        4'b0000, 32'h0,        1);
    vt[8]  = mk(0, 1, 3'b001, 32'h103, 32'h0000FFFF, 32'h0,        4'b0000, 32'h0,        1);
    vt[9]  = mk(1, 0, 3'b101, 32'h305, 32'h0,        32'h0,        4'b0000, 32'h0,        1);
    vt[10] = mk(1, 0, 3'b100, 32'h003, 32'h000000FF, 32'h0A0B0C0D, 4'b1000, 32'hFF000000, 0);
    vt[11] = mk(1, 1, 3'b010, 32'h010, 32'h01020304, 32'h99999999, 4'b1111, 32'h01020304, 0);
    vt[12] = mk(0, 1, 3'b001, 32'h100, 32'h0000FFFF, 32'h0,        4'b0011, 32'h0000FFFF, 0);

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst data_read", {31'b0, data_read_o}, 32'h0);
    chk("rst data_write", {31'b0, data_write_o}, 32'h0);
    chk("rst data_addr", data_addr_o, 32'h0);
    chk("rst mbe", {28'b0, data_mbe_o}, 32'h0);
    chk("rst wdata", data_wdata_o, 32'h0);
    chk("rst load_data", load_data_o, 32'h0);
    chk("rst stall", {31'b0, stall_o}, 32'h0);
    chk("rst timeout", {31'b0, timeout_o}, 32'h0);
    @(posedge clk); #1 rst = 0;

    // Table of single accesses, each answered in its first REQ cycle
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      issue(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].sd);
      @(negedge clk);
      chk($sformatf("v%0d misalign", i), {31'b0, misalign_o}, {31'b0, vt[i].mis});
      chk($sformatf("v%0d idle stall", i), {31'b0, stall_o}, {31'b0, ~vt[i].mis});
      @(posedge clk); #1;
      if (vt[i].mis) begin
        chk($sformatf("v%0d no read", i), {31'b0, data_read_o}, 32'h0);
        chk($sformatf("v%0d no write", i), {31'b0, data_write_o}, 32'h0);
        chk($sformatf("v%0d no stall", i), {31'b0, stall_o}, 32'h0);
        drive_idle();
        continue;
      end
      chk($sformatf("v%0d data_read", i), {31'b0, data_read_o}, {31'b0, vt[i].rd & ~vt[i].wr});
      chk($sformatf("v%0d data_write", i), {31'b0, data_write_o}, {31'b0, vt[i].wr});
      chk($sformatf("v%0d addr", i), data_addr_o, vt[i].addr & ~32'h3);
      chk($sformatf("v%0d mbe", i), {28'b0, data_mbe_o}, {28'b0, vt[i].mbe});
      chk($sformatf("v%0d wdata", i), data_wdata_o, vt[i].wdata);
      chk($sformatf("v%0d req stall", i), {31'b0, stall_o}, 32'h1);
      data_resp_i = 1; data_rdata_i = vt[i].rdata; pipe_advance_i = 1;
      if (vt[i].rd && !vt[i].wr) last_load = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d resp stall", i), {31'b0, stall_o}, 32'h0);
      @(posedge clk); #1;
      drive_idle();
      chk($sformatf("v%0d drop read", i), {31'b0, data_read_o}, 32'h0);
      chk($sformatf("v%0d drop write", i), {31'b0, data_write_o}, 32'h0);
      chk($sformatf("v%0d load_data", i), load_data_o, last_load);
    end

    // SW with the response three cycles after the request appears: 4 stall cycles
    @(posedge clk); #1;
    issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF);
    stalls = 0; reqs = 0;
    @(negedge clk);
    if (stall_o) stalls++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (data_write_o) reqs++;
      @(negedge clk);
      if (stall_o) stalls++;
    end
    @(posedge clk); #1;
    data_resp_i = 1; pipe_advance_i = 1;
    @(negedge clk);
    if (stall_o) stalls++;
    chk("sw held request cycles", reqs, 3);
    chk("sw addr", data_addr_o, 32'h100);
    chk("sw wdata", data_wdata_o, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive_idle();
    chk("sw stall cycles", stalls, 4);
    chk("sw write dropped", {31'b0, data_write_o}, 32'h0);

    // Response while the pipeline is frozen elsewhere: DONE, no reissue
    @(posedge clk); #1;
    issue(1, 0, 3'b010, 32'h400, 32'h0);
    @(posedge clk); #1;
    data_resp_i = 1; data_rdata_i = 32'h0BADF00D;
    @(posedge clk); #1;
    data_resp_i = 0; data_rdata_i = 32'h0;
    reqs = 0; stalls = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (data_read_o) reqs++;
      @(posedge clk); #1;
    end
    chk("done no reissue", reqs, 0);
    chk("done no stall", stalls, 0);
    chk("done load_data", load_data_o, 32'h0BADF00D);
    pipe_advance_i = 1;
    @(posedge clk); #1;
    drive_idle();
    issue(1, 0, 3'b000, 32'h404, 32'h0);
    @(negedge clk);
    chk("resume idle stall", {31'b0, stall_o}, 32'h1);
    @(posedge clk); #1;
    chk("resume new read", {31'b0, data_read_o}, 32'h1);
    chk("resume mbe", {28'b0, data_mbe_o}, 32'h1);
    data_resp_i = 1; data_rdata_i = 32'h00000077; pipe_advance_i = 1;
    @(posedge clk); #1;
    drive_idle();
    chk("resume load_data", load_data_o, 32'h00000077);

    // Reset while in REQ, late response ignored
    @(posedge clk); #1;
    issue(1, 0, 3'b010, 32'h600, 32'h0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    drive_idle();
    data_resp_i = 1; data_rdata_i = 32'h12345678;
    @(negedge clk);
    chk("rstreq stall", {31'b0, stall_o}, 32'h0);
    chk("rstreq read", {31'b0, data_read_o}, 32'h0);
    @(posedge clk); #1;
    data_resp_i = 0;
    chk("rstreq load_data", load_data_o, 32'h0);
    chk("rstreq addr", data_addr_o, 32'h0);

    // Watchdog: no response, timeout after MAX_WAIT cycles in REQ
    @(posedge clk); #1;
    issue(1, 0, 3'b010, 32'h500, 32'h0);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) chk("wd not yet", {31'b0, timeout_o}, 32'h0);
      if (k == 4) begin
        chk("wd timeout", {31'b0, timeout_o}, 32'h1);
        chk("wd request held", {31'b0, data_read_o}, 32'h1);
      end
    end
    data_resp_i = 1; data_rdata_i = 32'h55AA55AA; pipe_advance_i = 1;
    @(posedge clk); #1;
    drive_idle();
    chk("wd sticky", {31'b0, timeout_o}, 32'h1);
    chk("wd load_data", load_data_o, 32'h55AA55AA);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("wd cleared by rst", {31'b0, timeout_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
